instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute control FSM for the 8-bit processor.
//  - Owns the PC and the instruction register (IR).
//  - Drives the Decoder: IR[7:0] -> inst, and selects isim4 per opcode.
//  - Uses the Decoder's imm8 for branch and jump targets.
//  - Handshakes with the unified memory and gates the ALU and register-file writes.
// PARAMETERS
//  RESET_PC        8'h00  PC value loaded on reset
//  TIMEOUT_CYCLES  15     mem_rdy wait limit; used only when BUS_TIMEOUT_EN is defined
// PORTS
//  clk           in   1  rising-edge clock
//  reset         in   1  synchronous, active-high reset
//  run           in   1  level; leave IDLE/HALT and start fetching
//  mem_rdy       in   1  memory done this cycle; read data valid on mem_rdata
//  mem_rdata     in   8  memory read data
//  imm8          in   8  sign-extended immediate from Decoder
//  zero_flag     in   1  ALU zero flag, sampled in EXEC
//  pc            out  8  program counter
//  ir            out  8  instruction register; feeds Decoder inst
//  isim4         out  1  to Decoder: 1 = 4-bit immediate, 0 = 2-bit immediate
//  mem_req       out  1  memory request; held until mem_rdy
//  mem_we        out  1  write strobe, qualified by mem_req
//  mem_addr_sel  out  1  0 = address from pc, 1 = address from register file
//  alu_en        out  1  one-cycle ALU enable
//  reg_we        out  1  one-cycle register-file write enable
//  wb_sel        out  1  0 = ALU result, 1 = mem_rdata
//  halted        out  1  high while in HALT
//  fault         out  1  sticky bus-timeout flag
//  state         out  3  FSM state, for debug
// BEHAVIOUR
//  Reset values (synchronous reset; wins over every other input, including mid-transfer):
//   pc = RESET_PC, ir = 8'h00, state = IDLE, all strobes = 0, halted = 0, fault = 0.
//  Opcode map (op = ir[7:4]):
//   0x0-0x7  ALU op, isim4 = 0
//   0x8      LDI, isim4 = 1
//   0x9      LD
//   0xA      ST
//   0xB      BEQ, isim4 = 1
//   0xC      JMP, isim4 = 1
//   0xD-0xE  reserved; execute as NOP
//   0xF      HALT
//  isim4 is combinational from ir[7:4]; it is valid from DECODE onward.
//  State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
//  IDLE: all strobes 0; go to FETCH when run = 1.
//  FETCH:
//   - mem_req = 1, mem_addr_sel = 0, mem_we = 0.
//   - On mem_rdy: ir <= mem_rdata, pc <= pc + 1 (mod 256), go to DECODE.
//  DECODE: one cycle; no strobes; Decoder output settles; go to EXEC.
//  EXEC (one cycle):
//   - ALU op: alu_en = 1 -> WB.
//   - LDI: alu_en = 1 (passes imm8) -> WB.
//   - LD / ST -> MEM.
//   - BEQ: if zero_flag, pc <= pc + imm8 (mod 256) -> FETCH.
//   - JMP: pc <= pc + imm8 -> FETCH.
//   - NOP -> FETCH.
//   - HALT -> HALT.
//  MEM:
//   - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for ST, 0 for LD.
//   - On mem_rdy: LD -> WB with wb_sel = 1; ST -> FETCH.
//  WB: reg_we = 1 for one cycle; wb_sel = 1 only for LD; go to FETCH.
//  HALT: halted = 1; pc frozen.
//   - A run level held through HALT does not restart; run must fall to 0 and rise again.
//   - On that rising edge of run: go to FETCH.
//  Handshakes and latency:
//   - mem_req, mem_addr_sel and mem_we stay stable until the mem_rdy cycle.
//   - mem_rdy outside FETCH/MEM is ignored.
//   - Latency with zero-wait memory: ALU op/LDI = 4 cycles; BEQ/JMP/NOP = 3; LD = 5; ST = 4.
//  Boundary cases:
//   - pc wraps 8'hFF -> 8'h00.
//   - Negative imm8 branches backward; the target is computed mod 256.
//   - run falling mid-instruction is ignored; the instruction completes.
//   - reset during a memory wait drops mem_req in the next cycle.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   - 4-bit wait counter runs in FETCH/MEM while mem_req = 1 and mem_rdy = 0.
//   - Counter clears on every state change.
//   - On reaching TIMEOUT_CYCLES: go to FAULT, set fault = 1, mem_req = 0.
//   - FAULT is left only by reset.
//  BUS_TIMEOUT_EN undefined:
//   - No counter; FETCH/MEM wait indefinitely; fault is tied to 0; FAULT is unreachable.
// TESTING
//  T1 Reset, zero-wait memory, mem = {8'h85, 8'hF0}, run = 1:
//     LDI asserts isim4 = 1 and reg_we; then HALT; halted = 1, pc = 8'h02.
//  T2 ir = 8'hB3 (BEQ), pc = 8'h10 after fetch, zero_flag = 1 -> pc = 8'h13.
//     Same with zero_flag = 0 -> pc stays 8'h10.
//  T3 JMP 8'hCE (imm8 = -2) fetched from 8'hFF:
//     pc wraps to 8'h00, then jumps to 8'hFE.
//  T4 LD with mem_rdy delayed 3 cycles:
//     mem_req held 4 cycles with mem_addr_sel = 1; then reg_we = 1 with wb_sel = 1.
//  T5 reset asserted mid-MEM wait:
//     next cycle mem_req = 0, state = IDLE, pc = RESET_PC.
//  T6 BUS_TIMEOUT_EN defined, mem_rdy never asserted:
//     fault = 1 after 15 wait cycles; state = FAULT until reset.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit processor: owns PC and IR, drives memory, ALU and register-file strobes.
// Optional bus-timeout watchdog (FAULT state, sticky fault flag) is enabled by defining BUS_TIMEOUT_EN.
module instr_sequencer #(
    parameter logic [7:0] RESET_PC       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mem_rdy,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] imm8,
    input  logic       zero_flag,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       isim4,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       alu_en,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       run_prev_q, run_prev_d;
    logic [3:0] op;
    logic       is_alu, is_ldi, is_ld, is_st, is_beq, is_jmp, is_halt;
    logic       timeout;

    assign op      = ir_q[7:4];
    assign is_alu  = ~op[3];
    assign is_ldi  = (op == 4'h8);
    assign is_ld   = (op == 4'h9);
    assign is_st   = (op == 4'hA);
    assign is_beq  = (op == 4'hB);
    assign is_jmp  = (op == 4'hC);
    assign is_halt = (op == 4'hF);

    assign run_prev_d = run;

`ifdef BUS_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       waiting;

    assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !mem_rdy;
    assign timeout = waiting && (wait_cnt_q == 4'(TIMEOUT_CYCLES - 1));

    // Counts consecutive wait cycles of the current memory access only.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = 4'd0;
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign fault = (state_q == FAULT);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign fault              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 8'h00;
            run_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            run_prev_q <= run_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (timeout) begin
                    state_d = FAULT;
                end else if (mem_rdy) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 8'd1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (is_alu || is_ldi) begin
                    state_d = WB;
                end else if (is_ld || is_st) begin
                    state_d = MEM;
                end else if (is_beq) begin
                    if (zero_flag) pc_d = pc_q + imm8;
                    state_d = FETCH;
                end else if (is_jmp) begin
                    pc_d    = pc_q + imm8;
                    state_d = FETCH;
                end else if (is_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (timeout) begin
                    state_d = FAULT;
                end else if (mem_rdy) begin
                    state_d = is_ld ? WB : FETCH;
                end
            end
            WB: state_d = FETCH;
            // Restart needs a fresh rising edge of run, not a level held from before HALT.
            HALT: begin
                if (run && !run_prev_q) state_d = FETCH;
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_en       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        isim4        = is_ldi || is_beq || is_jmp;
        case (state_q)
            FETCH: mem_req = 1'b1;
            EXEC:  alu_en  = is_alu || is_ldi;
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_st;
            end
            WB: begin
                reg_we = 1'b1;
                wb_sel = is_ld;
            end
            HALT:    halted = 1'b1;
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign pc    = pc_q;
    assign ir    = ir_q;
    assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Table-driven bench for instr_sequencer: per-cycle input vectors with hand-computed expected outputs,
// plus a hand-written memory-wait sequence whose expectation depends on BUS_TIMEOUT_EN.
module tb_instr_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    // Strobe bit order: {mem_req, mem_we, mem_addr_sel, alu_en, reg_we, wb_sel, isim4, halted, fault}
    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] REQ  = 9'h100;
    localparam logic [8:0] WE   = 9'h080;
    localparam logic [8:0] ASEL = 9'h040;
    localparam logic [8:0] ALU  = 9'h020;
    localparam logic [8:0] RWE  = 9'h010;
    localparam logic [8:0] WBS  = 9'h008;
    localparam logic [8:0] ISIM = 9'h004;
    localparam logic [8:0] HLT  = 9'h002;
    localparam logic [8:0] FLT  = 9'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       mem_rdy;
    logic [7:0] mem_rdata;
    logic [7:0] imm8;
    logic       zero_flag;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       isim4;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       alu_en;
    logic       reg_we;
    logic       wb_sel;
    logic       halted;
    logic       fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .mem_rdy      (mem_rdy),
        .mem_rdata    (mem_rdata),
        .imm8         (imm8),
        .zero_flag    (zero_flag),
        .pc           (pc),
        .ir           (ir),
        .isim4        (isim4),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_en       (alu_en),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .fault        (fault),
        .state        (state)
    );

    typedef struct {
        logic       rst;
        logic       run;
        logic       rdy;
        logic [7:0] rdata;
        logic [7:0] imm;
        logic       zf;
        logic [2:0] st;
        logic [7:0] pc;
        logic [7:0] ir;
        logic [8:0] strb;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic ru, input logic rd, input logic [7:0] d,
                           input logic [7:0] im, input logic z, input logic [2:0] s,
                           input logic [7:0] p, input logic [7:0] i, input logic [8:0] b);
        vec_t v;
        v.rst = r; v.run = ru; v.rdy = rd; v.rdata = d; v.imm = im; v.zf = z;
        v.st = s; v.pc = p; v.ir = i; v.strb = b;
        vecs.push_back(v);
    endtask

    // Inputs change one time unit after the edge; outputs are sampled one unit after the next edge.
    task automatic apply_stimulus(input logic r, input logic ru, input logic rd, input logic [7:0] d,
                                  input logic [7:0] im, input logic z);
        reset = r; run = ru; mem_rdy = rd; mem_rdata = d; imm8 = im; zero_flag = z;
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name, input string field, input logic [8:0] act,
                           input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic [2:0] s, input logic [7:0] p,
                                input logic [7:0] i, input logic [8:0] b);
        compare(name, "state", {6'd0, state}, {6'd0, s});
        compare(name, "pc", {1'b0, pc}, {1'b0, p});
        compare(name, "ir", {1'b0, ir}, {1'b0, i});
        compare(name, "strobes",
                {mem_req, mem_we, mem_addr_sel, alu_en, reg_we, wb_sel, isim4, halted, fault}, b);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // T1: reset, LDI then HALT, HALT ignores a held run and restarts on a fresh rising edge
        add_vec(1,0,0,8'h00,8'h00,0, S_IDLE,   8'h00,8'h00, NONE);
        add_vec(0,1,0,8'h00,8'h00,0, S_FETCH,  8'h00,8'h00, REQ);
        add_vec(0,1,1,8'h85,8'h00,0, S_DECODE, 8'h01,8'h85, ISIM);
        add_vec(0,1,0,8'h00,8'h05,0, S_EXEC,   8'h01,8'h85, ALU|ISIM);
        add_vec(0,1,0,8'h00,8'h00,0, S_WB,     8'h01,8'h85, RWE|ISIM);
        add_vec(0,1,0,8'h00,8'h00,0, S_FETCH,  8'h01,8'h85, REQ|ISIM);
        add_vec(0,1,1,8'hF0,8'h00,0, S_DECODE, 8'h02,8'hF0, NONE);
        add_vec(0,1,0,8'h00,8'h00,0, S_EXEC,   8'h02,8'hF0, NONE);
        add_vec(0,1,0,8'h00,8'h00,0, S_HALT,   8'h02,8'hF0, HLT);
        add_vec(0,1,1,8'h00,8'h00,0, S_HALT,   8'h02,8'hF0, HLT);
        add_vec(0,0,0,8'h00,8'h00,0, S_HALT,   8'h02,8'hF0, HLT);
        add_vec(0,1,0,8'h00,8'h00,0, S_FETCH,  8'h02,8'hF0, REQ);
        // T2: JMP to 0x0F, BEQ taken (0x10 -> 0x13), BEQ not taken (pc stays 0x14)
        add_vec(1,1,0,8'h00,8'h00,0, S_IDLE,   8'h00,8'h00, NONE);
        add_vec(0,1,0,8'h00,8'h00,0, S_FETCH,  8'h00,8'h00, REQ);
        add_vec(0,1,1,8'hC0,8'h00,0, S_DECODE, 8'h01,8'hC0, ISIM);
        add_vec(0,1,0,8'h00,8'h00,0, S_EXEC,   8'h01,8'hC0, ISIM);
        add_vec(0,1,0,8'h00,8'h0E,0, S_FETCH,  8'h0F,8'hC0, REQ|ISIM);
        add_vec(0,1,1,8'hB3,8'h00,0, S_DECODE, 8'h10,8'hB3, ISIM);
        add_vec(0,1,0,8'h00,8'h03,0, S_EXEC,   8'h10,8'hB3, ISIM);
        add_vec(0,1,0,8'h00,8'h03,1, S_FETCH,  8'h13,8'hB3, REQ|ISIM);
        add_vec(0,1,1,8'hB3,8'h00,0, S_DECODE, 8'h14,8'hB3, ISIM);
        add_vec(0,1,0,8'h00,8'h03,1, S_EXEC,   8'h14,8'hB3, ISIM);
        add_vec(0,1,0,8'h00,8'h03,0, S_FETCH,  8'h14,8'hB3, REQ|ISIM);
        // T3: JMP to 0xFF, JMP -2 fetched from 0xFF wraps pc to 0x00 then lands on 0xFE
        add_vec(0,1,1,8'hC0,8'h00,0, S_DECODE, 8'h15,8'hC0, ISIM);
        add_vec(0,1,0,8'h00,8'h00,0, S_EXEC,   8'h15,8'hC0, ISIM);
        add_vec(0,1,0,8'h00,8'hEA,0, S_FETCH,  8'hFF,8'hC0, REQ|ISIM);
        add_vec(0,1,1,8'hCE,8'h00,0, S_DECODE, 8'h00,8'hCE, ISIM);
        add_vec(0,1,0,8'h00,8'h00,0, S_EXEC,   8'h00,8'hCE, ISIM);
        add_vec(0,1,0,8'h00,8'hFE,0, S_FETCH,  8'hFE,8'hCE, REQ|ISIM);
        // T4: LD with 3 wait cycles (run low, stray mem_rdy in DECODE), then ST
        add_vec(0,1,1,8'h90,8'h00,0, S_DECODE, 8'hFF,8'h90, NONE);
        add_vec(0,0,1,8'h00,8'h00,0, S_EXEC,   8'hFF,8'h90, NONE);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'hFF,8'h90, REQ|ASEL);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'hFF,8'h90, REQ|ASEL);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'hFF,8'h90, REQ|ASEL);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'hFF,8'h90, REQ|ASEL);
        add_vec(0,0,1,8'h5A,8'h00,0, S_WB,     8'hFF,8'h90, RWE|WBS);
        add_vec(0,0,0,8'h00,8'h00,0, S_FETCH,  8'hFF,8'h90, REQ);
        add_vec(0,0,1,8'hA0,8'h00,0, S_DECODE, 8'h00,8'hA0, NONE);
        add_vec(0,0,0,8'h00,8'h00,0, S_EXEC,   8'h00,8'hA0, NONE);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'h00,8'hA0, REQ|WE|ASEL);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'h00,8'hA0, REQ|WE|ASEL);
        add_vec(0,0,1,8'h00,8'h00,0, S_FETCH,  8'h00,8'hA0, REQ);
        add_vec(0,0,1,8'h90,8'h00,0, S_DECODE, 8'h01,8'h90, NONE);
        add_vec(0,0,0,8'h00,8'h00,0, S_EXEC,   8'h01,8'h90, NONE);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'h01,8'h90, REQ|ASEL);
        add_vec(0,0,0,8'h00,8'h00,0, S_MEM,    8'h01,8'h90, REQ|ASEL);
        // T5: reset during the MEM wait wins even with mem_rdy high
        add_vec(1,1,1,8'h77,8'h00,0, S_IDLE,   8'h00,8'h00, NONE);
        add_vec(0,0,0,8'h00,8'h00,0, S_IDLE,   8'h00,8'h00, NONE);
        // Reserved opcode runs as a 3-cycle NOP; ALU op takes 4 cycles
        add_vec(0,1,0,8'h00,8'h00,0, S_FETCH,  8'h00,8'h00, REQ);
        add_vec(0,1,1,8'hD5,8'h00,0, S_DECODE, 8'h01,8'hD5, NONE);
        add_vec(0,1,0,8'h00,8'h00,0, S_EXEC,   8'h01,8'hD5, NONE);
        add_vec(0,1,0,8'h00,8'h00,0, S_FETCH,  8'h01,8'hD5, REQ);
        add_vec(0,1,1,8'h37,8'h00,0, S_DECODE, 8'h02,8'h37, NONE);
        add_vec(0,1,0,8'h00,8'h00,0, S_EXEC,   8'h02,8'h37, ALU);
        add_vec(0,1,0,8'h00,8'h00,0, S_WB,     8'h02,8'h37, RWE);
        add_vec(0,1,0,8'h00,8'h00,0, S_FETCH,  8'h02,8'h37, REQ);

        $display("[TB] applying %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].run, vecs[i].rdy, vecs[i].rdata, vecs[i].imm, vecs[i].zf);
            check_output($sformatf("vec%0d", i), vecs[i].st, vecs[i].pc, vecs[i].ir, vecs[i].strb);
        end

`ifdef BUS_TIMEOUT_EN
        // T6: 14 wait cycles stay in FETCH, the 15th enters FAULT, which only reset leaves
        for (int i = 1; i <= 14; i++) begin
            apply_stimulus(0, 1, 0, 8'h00, 8'h00, 0);
            check_output($sformatf("wait%0d", i), S_FETCH, 8'h02, 8'h37, REQ);
        end
        apply_stimulus(0, 1, 0, 8'h00, 8'h00, 0);
        check_output("timeout", S_FAULT, 8'h02, 8'h37, FLT);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 1, 1, 8'hF0, 8'h00, 0);
            check_output($sformatf("fault_hold%0d", i), S_FAULT, 8'h02, 8'h37, FLT);
        end
        apply_stimulus(1, 0, 0, 8'h00, 8'h00, 0);
        check_output("fault_reset", S_IDLE, 8'h00, 8'h00, NONE);
`else
        // Without the watchdog a fetch waits indefinitely with its request held
        for (int i = 1; i <= 20; i++) begin
            apply_stimulus(0, 1, 0, 8'h00, 8'h00, 0);
            check_output($sformatf("wait%0d", i), S_FETCH, 8'h02, 8'h37, REQ);
        end
        apply_stimulus(0, 1, 1, 8'hF0, 8'h00, 0);
        check_output("late_rdy", S_DECODE, 8'h03, 8'hF0, NONE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
